// File: rtl/rs232_tx_fifo.sv
// Byte FIFO feeding the synchronous RS232 transmitter: buffers host bursts and
// issues them one at a time over the ena_tx / tx_data / tx_busy handshake.
module rs232_tx_fifo #(
    parameter int unsigned DEPTH_BITS        = 4,
    parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_ena,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   fill_count,
    output logic                  overflow,
    output logic                  uart_ena_tx,
    output logic [7:0]            uart_tx_data,
    input  logic                  uart_tx_busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;
    localparam int unsigned PW    = DEPTH_BITS;
    localparam int unsigned CW    = DEPTH_BITS + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            ack_cnt;
    logic            ack_cnt_nxt;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            wr_acc_c;
    logic            issue_ok_c;
    logic            pop_c;
    logic [CW-1:0]   fill_nxt_c;

    // Full rejects even if a pop happens on the same edge; flush wins over writes.
    assign wr_acc_c   = wr_ena & ~flush & ~full;
    assign issue_ok_c = ~empty & ~uart_tx_busy & ~flush;

    // FSM state register; ack_cnt counts cycles spent waiting for tx_busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ack_cnt <= 1'b0;
        end else begin
            state   <= state_nxt;
            ack_cnt <= ack_cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt   = state;
        ack_cnt_nxt = ack_cnt;
        case (state)
            IDLE: begin
                if (issue_ok_c) begin
                    state_nxt   = WAIT_ACK;
                    ack_cnt_nxt = 1'b0;
                end
            end
            WAIT_ACK: begin
                if (uart_tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (ack_cnt) begin
                    state_nxt = IDLE;
                end else begin
                    ack_cnt_nxt = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: pop the head only from IDLE with the UART free.
    always_comb begin
        pop_c = 1'b0;
        if (state == IDLE) begin
            pop_c = issue_ok_c;
        end
    end

    always_comb begin
        fill_nxt_c = fill_count;
        if (flush) begin
            fill_nxt_c = '0;
        end else if (wr_acc_c && !pop_c) begin
            fill_nxt_c = fill_count + CW'(1);
        end else if (pop_c && !wr_acc_c) begin
            fill_nxt_c = fill_count - CW'(1);
        end
    end

    // Pointers, status flags and UART-facing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_count   <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            uart_ena_tx  <= 1'b0;
            uart_tx_data <= 8'hFF;
        end else begin
            fill_count  <= fill_nxt_c;
            empty       <= (fill_nxt_c == '0);
            full        <= (fill_nxt_c == CW'(DEPTH));
            almost_full <= (fill_nxt_c >= CW'(ALMOST_FULL_LEVEL));
            uart_ena_tx <= pop_c;
            if (pop_c) begin
                uart_tx_data <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_acc_c) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop_c) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (wr_ena && full) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Storage array needs no reset; fill_count guards every read.
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Scoreboard bench for rs232_tx_fifo: byte-queue reference model plus a
// behavioural UART that answers ena_tx with a tx_busy window.
module tb_rs232_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic       wr_ena = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, almost_full, empty, overflow, uart_ena_tx, uart_tx_busy;
    logic [4:0] fill_count;
    logic [7:0] uart_tx_data;

    int total = 0;
    int bad   = 0;

    // Reference model: bytes held, bytes handed to the UART, transmit slot.
    byte unsigned m_q[$];
    byte unsigned exp_tx[$];
    bit           m_ovf  = 1'b0;
    bit           m_pop  = 1'b0;
    logic [7:0]   m_data = 8'hFF;
    int           m_slot = 0;
    int           m_age  = 0;
    int           mn;
    bit           macc;

    // UART model: 0 answers with busy window, 1 holds busy, 2 never raises busy.
    int u_mode = 0;
    int u_lo   = 1;
    int u_hi   = 8;
    int u_cnt  = 0;
    bit prev_ena = 1'b0;

    rs232_tx_fifo #(.DEPTH_BITS(4), .ALMOST_FULL_LEVEL(AF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_ena       (wr_ena),
        .wr_data      (wr_data),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .fill_count   (fill_count),
        .overflow     (overflow),
        .uart_ena_tx  (uart_ena_tx),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model advances on each edge using pre-edge inputs.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            exp_tx.delete();
            m_ovf  = 1'b0;
            m_pop  = 1'b0;
            m_data = 8'hFF;
            m_slot = 0;
            m_age  = 0;
        end else begin
            mn    = m_q.size();
            m_pop = (m_slot == 0) && (mn != 0) && !uart_tx_busy && !flush;
            macc  = wr_ena && !flush && (mn < DEPTH);
            if (flush) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else begin
                if (m_pop) begin
                    m_data = m_q.pop_front();
                    exp_tx.push_back(m_data);
                end
                if (macc) m_q.push_back(wr_data);
                if (wr_ena && mn == DEPTH) m_ovf = 1'b1;
            end
            if (m_slot == 0) begin
                if (m_pop) begin
                    m_slot = 1;
                    m_age  = 0;
                end
            end else if (m_slot == 1) begin
                if (uart_tx_busy) m_slot = 2;
                else if (m_age >= 1) m_slot = 0;
                else m_age++;
            end else if (!uart_tx_busy) begin
                m_slot = 0;
            end
        end
    end

    // Behavioural UART: busy rises the clock after ena_tx and lasts u_cnt cycles.
    initial begin
        uart_tx_busy = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                u_cnt = 0;
                uart_tx_busy <= 1'b0;
            end else begin
                if (uart_ena_tx && u_mode == 0) u_cnt = $urandom_range(u_hi, u_lo);
                else if (u_cnt > 0) u_cnt--;
                uart_tx_busy <= (u_mode == 1) || (u_cnt > 0);
            end
        end
    end

    // Monitor: status against the model, transmitted bytes against the scoreboard.
    initial forever begin
        @(negedge clk);
        chk("fill_count", int'(fill_count), m_q.size());
        chk("empty", int'(empty), int'(m_q.size() == 0));
        chk("full", int'(full), int'(m_q.size() == DEPTH));
        chk("almost_full", int'(almost_full), int'(m_q.size() >= AF));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("ena_tx", int'(uart_ena_tx), int'(m_pop));
        chk("tx_data_hold", int'(uart_tx_data), int'(m_data));
        chk("ena_consecutive", int'(uart_ena_tx && prev_ena), 0);
        if (uart_ena_tx) begin
            chk("sb_nonempty", int'(exp_tx.size() != 0), 1);
            if (exp_tx.size() != 0) chk("sb_byte", int'(uart_tx_data), int'(exp_tx.pop_front()));
        end
        prev_ena = uart_ena_tx;
    end

    task automatic cyc(bit we, logic [7:0] d, bit fl);
        @(negedge clk);
        wr_ena  = we;
        wr_data = d;
        flush   = fl;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((m_q.size() != 0 || m_slot != 0) && n < budget) begin
            cyc(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("drain_in_budget", int'(n < budget), 1);
        repeat (4) cyc(1'b0, 8'h00, 1'b0);
    endtask

    int rate;
    int sel;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single byte, UART idle.
        cyc(1'b1, 8'h55, 1'b0);
        drain(50);

        // Fill under held busy, overflow on the 17th, then drain in order.
        u_mode = 1;
        for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        u_mode = 0;
        drain(400);
        cyc(1'b0, 8'h00, 1'b1);

        // Near-full with writes overlapping pops; pointers wrap.
        u_mode = 1;
        for (int i = 0; i < 15; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
        u_mode = 0;
        for (int i = 0; i < 12; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
        drain(600);

        // Flush with a same-cycle write while the FSM waits for busy to fall.
        u_lo = 20;
        u_hi = 20;
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'hAA, 1'b1);
        drain(100);
        u_lo = 1;
        u_hi = 8;

        // Asynchronous reset between clock edges.
        u_mode = 1;
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_fill", int'(fill_count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_full", int'(full), 0);
        chk("arst_almost_full", int'(almost_full), 0);
        chk("arst_overflow", int'(overflow), 0);
        chk("arst_ena", int'(uart_ena_tx), 0);
        chk("arst_data", int'(uart_tx_data), 8'hFF);
        u_mode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 8'h3C, 1'b0);
        drain(50);

        // Randomized traffic with varying write rate and UART behaviour.
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                rate   = $urandom_range(95, 5);
                sel    = $urandom_range(9, 0);
                u_mode = (sel == 0) ? 2 : (sel == 1) ? 1 : 0;
            end
            cyc($urandom_range(99, 0) < rate, 8'($urandom), $urandom_range(63, 0) == 0);
        end
        u_mode = 0;
        drain(600);
        chk("sb_leftover", exp_tx.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
